alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
// PURPOSE
//  Issues decoded data-processing instructions to the registered ALU, one at a time.
//  Holds the architectural NZCV flags and evaluates the ARM condition field.
//  Captures the ALU result one cycle after issue and hands it to register-file writeback.
//  Sits between the decode stage and the register file; the ALU is instantiated alongside it.
// PARAMETERS
//  DATA_WIDTH  32  operand/result width; must match the ALU dataWidth
//  RD_W        4   destination register index width
//  SKIP_W      16  width of the skipped-instruction counter
// PORTS
//  clk           in   1           single clock; all state on posedge
//  rst           in   1           asynchronous, active-high reset
//  in_valid      in   1           decode offers an instruction
//  in_ready      out  1           sequencer accepts; transfer when in_valid && in_ready
//  in_cond       in   4           ARM condition field
//  in_opcode     in   4           ALU opcode (0000 AND .. 1111 MVN)
//  in_setcond    in   1           S bit
//  in_a, in_b    in   DATA_WIDTH  operands
//  in_rd         in   RD_W        destination register
//  alu_enable    out  1           ALU enable; high for exactly one cycle per issue
//  alu_opcode    out  4           latched opcode
//  alu_a, alu_b  out  DATA_WIDTH  latched operands
//  alu_carry     out  1           current flag C
//  alu_setcond   out  1           latched S bit
//  alu_result    in   DATA_WIDTH  ALU registered result
//  alu_n/z/c/v   in   1           ALU registered flags
//  alu_write_reg in   1           ALU says result is architecturally written
//  wb_valid      out  1           writeback offer
//  wb_ready      in   1           register file accepts
//  wb_rd         out  RD_W        writeback destination
//  wb_data       out  DATA_WIDTH  writeback data
//  flags_nzcv    out  4           architectural flags {N,Z,C,V}
//  skip_count    out  SKIP_W      instructions dropped by the condition check (wraps)
//  busy          out  1           state != IDLE
// BEHAVIOUR
//  Reset (async): state=IDLE; in_ready=1; alu_enable=0; wb_valid=0; flags_nzcv=0; skip_count=0.
//    All latched fields are cleared to 0.
//  FSM states: IDLE, ISSUE, CAPTURE, WB. in_ready=1 only in IDLE. There is no overlap:
//    at most one instruction is in flight.
//  IDLE: on handshake, latch opcode/a/b/setcond/rd and evaluate in_cond against the current
//    flags_nzcv.
//    - cond true  -> ISSUE.
//    - cond false -> stay IDLE, skip_count+1. The instruction is consumed; in_ready stays 1.
//  Condition codes: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z,
//    LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), 1110 AL always, 1111 never.
//  ISSUE (1 cycle): alu_enable=1 with latched operands and alu_carry=flags C.
//    The ALU registers its outputs on the closing edge. Next state: CAPTURE.
//  CAPTURE (1 cycle): sample alu_result/flags.
//    - If latched setcond=1: flags_nzcv <= {alu_n,alu_z,alu_c,alu_v}. If 0: flags unchanged
//      (the ALU's zeroed flags are ignored).
//    - Load wb_data/wb_rd.
//    - alu_write_reg=1 -> WB; else (TST/TEQ/CMP/CMN) -> IDLE.
//  WB: wb_valid=1; wb_rd and wb_data stay stable until wb_ready. On wb_valid&&wb_ready go to
//    IDLE; wb_valid drops the next cycle.
//  Latency: handshake at edge T -> alu_enable during cycle T..T+1 -> flags/wb_data update at
//    edge T+2 -> wb_valid high from edge T+2. Minimum 3 cycles per writing instruction with
//    wb_ready=1, 2 for compare-type.
//  Flag forwarding is implicit: flags are updated before the return to IDLE, so a conditional
//    instruction accepted right after a setcond instruction sees the new flags.
//  skip_count wraps from all-ones to 0.
//  Reset mid-operation returns to IDLE immediately. An in-flight result is discarded.
//    The ALU has no reset; its stale outputs are never sampled outside CAPTURE.
// STRUCTURE
//  alu_pkg: opcode constants (AND..MVN), cond_e enum (EQ..NV), seq_state_e enum,
//    NZCV bit indices.
//  Sub-module alu_cond_check: combinational (cond, nzcv) -> pass. It is reused by the
//    branch unit.
// TESTING
//  1. ADD AL a=5 b=7 S=1, wb_ready=1 -> alu_enable pulse 1 cycle; wb_data=12, wb_rd=in_rd;
//     flags=0000; 3 cycles.
//  2. CMP a=9 b=9 S=1 -> no wb_valid; flags Z=1. Then MOVEQ b=0xAB -> wb_data=0xAB.
//     Then MOVNE -> dropped, skip_count=1.
//  3. ADD S=1 a=0xFFFFFFFF b=1 -> wb_data=0, flags N=0 Z=1 C=1.
//     Then ADC a=1 b=1 -> wb_data=3 (alu_carry=1).
//  4. wb_ready held low 5 cycles after ADD -> wb_valid, wb_data and wb_rd stable; in_ready=0;
//     accept only after the wb handshake.
//  5. rst asserted during CAPTURE -> next cycle state IDLE, wb_valid=0, flags=0, in_ready=1;
//     no writeback.
//  6. cond=1111 on 3 instructions; skip_count preset near 0xFFFF -> no alu_enable;
//     count wraps to 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU/sequencer definitions: opcodes, ARM condition codes, FSM states, NZCV bit positions.
package alu_pkg;

   localparam int unsigned OPC_W  = 4;
   localparam int unsigned COND_W = 4;
   localparam int unsigned NZCV_W = 4;

   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

   localparam logic [OPC_W-1:0] OP_AND = 4'h0;
   localparam logic [OPC_W-1:0] OP_EOR = 4'h1;
   localparam logic [OPC_W-1:0] OP_SUB = 4'h2;
   localparam logic [OPC_W-1:0] OP_RSB = 4'h3;
   localparam logic [OPC_W-1:0] OP_ADD = 4'h4;
   localparam logic [OPC_W-1:0] OP_ADC = 4'h5;
   localparam logic [OPC_W-1:0] OP_SBC = 4'h6;
   localparam logic [OPC_W-1:0] OP_RSC = 4'h7;
   localparam logic [OPC_W-1:0] OP_TST = 4'h8;
   localparam logic [OPC_W-1:0] OP_TEQ = 4'h9;
   localparam logic [OPC_W-1:0] OP_CMP = 4'hA;
   localparam logic [OPC_W-1:0] OP_CMN = 4'hB;
   localparam logic [OPC_W-1:0] OP_ORR = 4'hC;
   localparam logic [OPC_W-1:0] OP_MOV = 4'hD;
   localparam logic [OPC_W-1:0] OP_BIC = 4'hE;
   localparam logic [OPC_W-1:0] OP_MVN = 4'hF;

   typedef enum logic [COND_W-1:0] {
      COND_EQ, COND_NE, COND_CS, COND_CC, COND_MI, COND_PL, COND_VS, COND_VC,
      COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_AL, COND_NV
   } cond_e;

   typedef enum logic [1:0] {
      ST_IDLE, ST_ISSUE, ST_CAPTURE, ST_WB
   } seq_state_e;

endpackage

// File: rtl/alu_cond_check.sv
// ARM condition-field evaluator: combinational (cond, NZCV) -> pass. Shared with the branch unit.
module alu_cond_check
   import alu_pkg::*;
(
   input  logic [COND_W-1:0] cond_i,
   input  logic [NZCV_W-1:0] nzcv_i,
   output logic              pass_c_o
);

   logic n, z, c, v;

   always_comb begin
      n        = nzcv_i[FLAG_N];
      z        = nzcv_i[FLAG_Z];
      c        = nzcv_i[FLAG_C];
      v        = nzcv_i[FLAG_V];
      pass_c_o = 1'b0;
      case (cond_i)
         COND_EQ: pass_c_o = z;
         COND_NE: pass_c_o = !z;
         COND_CS: pass_c_o = c;
         COND_CC: pass_c_o = !c;
         COND_MI: pass_c_o = n;
         COND_PL: pass_c_o = !n;
         COND_VS: pass_c_o = v;
         COND_VC: pass_c_o = !v;
         COND_HI: pass_c_o = c && !z;
         COND_LS: pass_c_o = !c || z;
         COND_GE: pass_c_o = (n == v);
         COND_LT: pass_c_o = (n != v);
         COND_GT: pass_c_o = !z && (n == v);
         COND_LE: pass_c_o = z || (n != v);
         COND_AL: pass_c_o = 1'b1;
         default: pass_c_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_sequencer.sv
// Issues one decoded instruction at a time to the registered ALU, owns NZCV, and hands
// the captured result to register-file writeback.
module alu_sequencer
   import alu_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned RD_W       = 4,
   parameter int unsigned SKIP_W     = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [COND_W-1:0]     in_cond,
   input  logic [OPC_W-1:0]      in_opcode,
   input  logic                  in_setcond,
   input  logic [DATA_WIDTH-1:0] in_a,
   input  logic [DATA_WIDTH-1:0] in_b,
   input  logic [RD_W-1:0]       in_rd,
   output logic                  alu_enable,
   output logic [OPC_W-1:0]      alu_opcode,
   output logic [DATA_WIDTH-1:0] alu_a,
   output logic [DATA_WIDTH-1:0] alu_b,
   output logic                  alu_carry,
   output logic                  alu_setcond,
   input  logic [DATA_WIDTH-1:0] alu_result,
   input  logic                  alu_n,
   input  logic                  alu_z,
   input  logic                  alu_c,
   input  logic                  alu_v,
   input  logic                  alu_write_reg,
   output logic                  wb_valid,
   input  logic                  wb_ready,
   output logic [RD_W-1:0]       wb_rd,
   output logic [DATA_WIDTH-1:0] wb_data,
   output logic [NZCV_W-1:0]     flags_nzcv,
   output logic [SKIP_W-1:0]     skip_count,
   output logic                  busy
);

   seq_state_e            state_q, state_d;
   logic [OPC_W-1:0]      opc_q, opc_d;
   logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic                  setcond_q, setcond_d;
   logic [RD_W-1:0]       rd_q, rd_d, wb_rd_q, wb_rd_d;
   logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
   logic [NZCV_W-1:0]     flags_q, flags_d;
   logic [SKIP_W-1:0]     skip_q, skip_d;
   logic                  in_ready_q, alu_enable_q, wb_valid_q, busy_q;
   logic                  cond_pass;

   alu_cond_check u_cond (
      .cond_i   (in_cond),
      .nzcv_i   (flags_q),
      .pass_c_o (cond_pass)
   );

   // Next-state: flags are written in CAPTURE, before IDLE, so the next accept sees them.
   always_comb begin
      state_d   = state_q;
      opc_d     = opc_q;
      a_d       = a_q;
      b_d       = b_q;
      setcond_d = setcond_q;
      rd_d      = rd_q;
      wb_rd_d   = wb_rd_q;
      wb_data_d = wb_data_q;
      flags_d   = flags_q;
      skip_d    = skip_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready_q) begin
               opc_d     = in_opcode;
               a_d       = in_a;
               b_d       = in_b;
               setcond_d = in_setcond;
               rd_d      = in_rd;
               if (cond_pass) state_d = ST_ISSUE;
               else           skip_d  = skip_q + SKIP_W'(1);
            end
         end
         ST_ISSUE: state_d = ST_CAPTURE;
         ST_CAPTURE: begin
            if (setcond_q) flags_d = {alu_n, alu_z, alu_c, alu_v};
            wb_data_d = alu_result;
            wb_rd_d   = rd_q;
            state_d   = alu_write_reg ? ST_WB : ST_IDLE;
         end
         ST_WB: begin
            if (wb_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Handshake-facing outputs are registered from the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         opc_q        <= '0;
         a_q          <= '0;
         b_q          <= '0;
         setcond_q    <= 1'b0;
         rd_q         <= '0;
         wb_rd_q      <= '0;
         wb_data_q    <= '0;
         flags_q      <= '0;
         skip_q       <= '0;
         in_ready_q   <= 1'b1;
         alu_enable_q <= 1'b0;
         wb_valid_q   <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         opc_q        <= opc_d;
         a_q          <= a_d;
         b_q          <= b_d;
         setcond_q    <= setcond_d;
         rd_q         <= rd_d;
         wb_rd_q      <= wb_rd_d;
         wb_data_q    <= wb_data_d;
         flags_q      <= flags_d;
         skip_q       <= skip_d;
         in_ready_q   <= (state_d == ST_IDLE);
         alu_enable_q <= (state_d == ST_ISSUE);
         wb_valid_q   <= (state_d == ST_WB);
         busy_q       <= (state_d != ST_IDLE);
      end
   end

   assign in_ready    = in_ready_q;
   assign alu_enable  = alu_enable_q;
   assign alu_opcode  = opc_q;
   assign alu_a       = a_q;
   assign alu_b       = b_q;
   assign alu_carry   = flags_q[FLAG_C];
   assign alu_setcond = setcond_q;
   assign wb_valid    = wb_valid_q;
   assign wb_rd       = wb_rd_q;
   assign wb_data     = wb_data_q;
   assign flags_nzcv  = flags_q;
   assign skip_count  = skip_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: behavioural ALU stub, reference model of flags,
// condition codes and skip counter, and a monitor checking issues and writebacks.
module tb_alu_sequencer;
   import alu_pkg::*;

   localparam int unsigned DW   = 32;
   localparam int unsigned RW   = 4;
   localparam int unsigned SW   = 8;
   localparam int unsigned SUMW = DW + 1;

   typedef struct packed { logic wr; logic [3:0] nzcv; logic [DW-1:0] res; } alu_out_t;
   typedef struct packed { logic [RW-1:0] rd; logic [DW-1:0] data; } wb_t;
   typedef struct packed { logic [3:0] op; logic [DW-1:0] a; logic [DW-1:0] b; logic s; logic c; } iss_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0, in_ready, in_setcond = 1'b0;
   logic [3:0]    in_cond = '0, in_opcode = '0;
   logic [DW-1:0] in_a = '0, in_b = '0;
   logic [RW-1:0] in_rd = '0;
   logic          alu_enable, alu_carry, alu_setcond;
   logic [3:0]    alu_opcode;
   logic [DW-1:0] alu_a, alu_b;
   logic [DW-1:0] alu_result = '0;
   logic          alu_n = 1'b0, alu_z = 1'b0, alu_c = 1'b0, alu_v = 1'b0, alu_write_reg = 1'b0;
   logic          wb_valid, wb_ready = 1'b1, busy;
   logic [RW-1:0] wb_rd;
   logic [DW-1:0] wb_data;
   logic [3:0]    flags_nzcv;
   logic [SW-1:0] skip_count;

   int checks = 0, fails = 0;
   int ready_mode = 1;              // 0 hold low, 1 hold high, 2 random
   logic [3:0] ref_flags = '0;
   int ref_skip = 0, exp_issues = 0, issues_seen = 0;
   wb_t  wb_q[$];
   iss_t iss_q[$];

   alu_sequencer #(.DATA_WIDTH(DW), .RD_W(RW), .SKIP_W(SW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_cond(in_cond),
      .in_opcode(in_opcode), .in_setcond(in_setcond), .in_a(in_a), .in_b(in_b), .in_rd(in_rd),
      .alu_enable(alu_enable), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
      .alu_carry(alu_carry), .alu_setcond(alu_setcond), .alu_result(alu_result),
      .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v), .alu_write_reg(alu_write_reg),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
      .flags_nzcv(flags_nzcv), .skip_count(skip_count), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   // Data-processing semantics in plain arithmetic; flags zeroed when S is clear.
   function automatic alu_out_t alu_ref(input logic [3:0] op, input logic [DW-1:0] a, b,
                                        input logic cin, input logic s);
      alu_out_t      o;
      logic [DW-1:0] x, y;
      logic          ci, arith;
      logic [DW:0]   sum;
      x = a; y = b; ci = 1'b0; arith = 1'b1;
      case (op)
         OP_SUB, OP_CMP: begin y = ~b; ci = 1'b1; end
         OP_RSB:         begin x = b; y = ~a; ci = 1'b1; end
         OP_ADD, OP_CMN: ci = 1'b0;
         OP_ADC:         ci = cin;
         OP_SBC:         begin y = ~b; ci = cin; end
         OP_RSC:         begin x = b; y = ~a; ci = cin; end
         default:        arith = 1'b0;
      endcase
      sum = {1'b0, x} + {1'b0, y} + SUMW'(ci);
      case (op)
         OP_AND, OP_TST: o.res = a & b;
         OP_EOR, OP_TEQ: o.res = a ^ b;
         OP_ORR:         o.res = a | b;
         OP_MOV:         o.res = b;
         OP_BIC:         o.res = a & ~b;
         OP_MVN:         o.res = ~b;
         default:        o.res = sum[DW-1:0];
      endcase
      o.wr = !(op inside {OP_TST, OP_TEQ, OP_CMP, OP_CMN});
      if (!s) o.nzcv = 4'b0000;
      else begin
         o.nzcv[3] = o.res[DW-1];
         o.nzcv[2] = (o.res == '0);
         o.nzcv[1] = arith ? sum[DW] : cin;
         o.nzcv[0] = arith ? ((x[DW-1] == y[DW-1]) && (sum[DW-1] != x[DW-1])) : 1'b0;
      end
      return o;
   endfunction

   function automatic bit cond_ok(input logic [3:0] cond, input logic [3:0] f);
      bit n, z, c, v;
      n = f[3]; z = f[2]; c = f[1]; v = f[0];
      case (cond)
         4'd0:  return z;
         4'd1:  return !z;
         4'd2:  return c;
         4'd3:  return !c;
         4'd4:  return n;
         4'd5:  return !n;
         4'd6:  return v;
         4'd7:  return !v;
         4'd8:  return c && !z;
         4'd9:  return !c || z;
         4'd10: return n == v;
         4'd11: return n != v;
         4'd12: return !z && (n == v);
         4'd13: return z || (n != v);
         4'd14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // ALU stub: registers results when enabled, otherwise drives garbage.
   alu_out_t stub_o;
   always @(posedge clk) begin
      if (alu_enable) begin
         stub_o = alu_ref(alu_opcode, alu_a, alu_b, alu_carry, alu_setcond);
         alu_result    <= stub_o.res;
         {alu_n, alu_z, alu_c, alu_v} <= stub_o.nzcv;
         alu_write_reg <= stub_o.wr;
      end else begin
         alu_result    <= $urandom;
         {alu_n, alu_z, alu_c, alu_v} <= 4'($urandom);
         alu_write_reg <= 1'($urandom);
      end
   end

   always @(posedge clk) begin
      #1;
      if (ready_mode == 2) wb_ready = 1'($urandom_range(0, 1));
      else                 wb_ready = (ready_mode == 1);
   end

   // Monitor: checks every ALU issue and every writeback against the queues.
   bit prev_en = 0, hold = 0;
   logic [RW-1:0] hold_rd;
   logic [DW-1:0] hold_data;
   iss_t ie;
   wb_t  we;
   always @(negedge clk) begin
      if (rst) begin
         prev_en = 0;
         hold    = 0;
      end else begin
         if (alu_enable) begin
            issues_seen++;
            check("alu_enable_single_cycle", 64'(prev_en), 64'(0));
            checks++;
            if (iss_q.size() == 0) begin
               fails++;
               $display("FAIL issue_q: alu_enable got 1 expected 0 (no pending issue)");
            end else begin
               ie = iss_q.pop_front();
               if ({alu_opcode, alu_a, alu_b, alu_setcond, alu_carry} !== ie) begin
                  fails++;
                  $display("FAIL issue_fields: got op=%0h a=%0h b=%0h s=%0b c=%0b expected op=%0h a=%0h b=%0h s=%0b c=%0b",
                           alu_opcode, alu_a, alu_b, alu_setcond, alu_carry, ie.op, ie.a, ie.b, ie.s, ie.c);
               end
            end
         end
         prev_en = alu_enable;
         if (wb_valid) begin
            if (hold) begin
               check("wb_rd_stable", 64'(wb_rd), 64'(hold_rd));
               check("wb_data_stable", 64'(wb_data), 64'(hold_data));
            end
            hold_rd = wb_rd; hold_data = wb_data;
            hold = !wb_ready;
            if (wb_ready) begin
               checks++;
               if (wb_q.size() == 0) begin
                  fails++;
                  $display("FAIL wb_q: wb handshake got rd=%0h data=%0h expected none", wb_rd, wb_data);
               end else begin
                  we = wb_q.pop_front();
                  if ({wb_rd, wb_data} !== we) begin
                     fails++;
                     $display("FAIL wb_data: got rd=%0h data=%0h expected rd=%0h data=%0h",
                              wb_rd, wb_data, we.rd, we.data);
                  end
               end
            end
         end else hold = 0;
      end
   end

   // mode: 0 wait idle+check, 1 latency check, 2 reset during CAPTURE, 3 return after handshake
   task automatic send(input logic [3:0] cond, input logic [3:0] op, input logic s,
                       input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [RW-1:0] rd, input int mode);
      alu_out_t r;
      bit pass;
      int t;
      in_cond = cond; in_opcode = op; in_setcond = s; in_a = a; in_b = b; in_rd = rd;
      in_valid = 1'b1;
      t = 0;
      while (!in_ready && t < 200) begin @(negedge clk); t++; end
      if (!in_ready) begin
         check("accept_timeout", 64'(in_ready), 64'(1));
         in_valid = 1'b0;
         return;
      end
      pass = cond_ok(cond, ref_flags);
      r = alu_ref(op, a, b, ref_flags[1], s);
      if (pass) begin
         iss_q.push_back('{op, a, b, s, ref_flags[1]});
         if (s) ref_flags = r.nzcv;
         if (r.wr) wb_q.push_back('{rd, r.res});
         exp_issues++;
      end else ref_skip = (ref_skip + 1) % (1 << SW);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      if (mode == 3) return;
      if (mode == 1) begin
         check("lat_t0_alu_enable", 64'(alu_enable), 64'(1));
         check("lat_t0_in_ready", 64'(in_ready), 64'(0));
         check("lat_t0_busy", 64'(busy), 64'(1));
         @(negedge clk);
         check("lat_t1_alu_enable", 64'(alu_enable), 64'(0));
         check("lat_t1_wb_valid", 64'(wb_valid), 64'(0));
         @(negedge clk);
         check("lat_t2_wb_valid", 64'(wb_valid), 64'(1));
         check("lat_t2_flags", 64'(flags_nzcv), 64'(ref_flags));
         @(negedge clk);
         check("lat_t3_in_ready", 64'(in_ready), 64'(1));
      end
      if (mode == 2) begin
         @(negedge clk);
         rst = 1'b1;
         @(negedge clk);
         check("rst_in_ready", 64'(in_ready), 64'(1));
         check("rst_wb_valid", 64'(wb_valid), 64'(0));
         check("rst_flags", 64'(flags_nzcv), 64'(0));
         check("rst_busy", 64'(busy), 64'(0));
         rst = 1'b0;
         ref_flags = '0;
         ref_skip  = 0;
         if (pass && r.wr) void'(wb_q.pop_back());
         repeat (3) begin
            @(negedge clk);
            check("rst_no_writeback", 64'(wb_valid), 64'(0));
         end
         return;
      end
      t = 0;
      while (!in_ready && t < 200) begin @(negedge clk); t++; end
      check("return_to_idle", 64'(in_ready), 64'(1));
      check("flags_nzcv", 64'(flags_nzcv), 64'(ref_flags));
      check("skip_count", 64'(skip_count), 64'(ref_skip));
      check("busy_idle", 64'(busy), 64'(0));
   endtask

   function automatic logic [DW-1:0] pick();
      case ($urandom_range(0, 5))
         0: return '0;
         1: return '1;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         4: return 32'h1;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      repeat (3) @(negedge clk);
      check("reset_in_ready", 64'(in_ready), 64'(1));
      check("reset_alu_enable", 64'(alu_enable), 64'(0));
      check("reset_wb_valid", 64'(wb_valid), 64'(0));
      check("reset_flags", 64'(flags_nzcv), 64'(0));
      check("reset_skip", 64'(skip_count), 64'(0));
      check("reset_busy", 64'(busy), 64'(0));
      rst = 1'b0;
      @(negedge clk);

      send(4'hE, OP_ADD, 1'b1, 32'd5, 32'd7, 4'd3, 1);
      send(4'hE, OP_CMP, 1'b1, 32'd9, 32'd9, 4'd0, 0);
      send(4'h0, OP_MOV, 1'b0, 32'd0, 32'hAB, 4'd5, 0);
      send(4'h1, OP_MOV, 1'b0, 32'd0, 32'hCD, 4'd6, 0);
      send(4'hE, OP_ADD, 1'b1, 32'hFFFF_FFFF, 32'd1, 4'd7, 0);
      send(4'hE, OP_ADC, 1'b0, 32'd1, 32'd1, 4'd8, 0);

      ready_mode = 0;
      send(4'hE, OP_ADD, 1'b0, 32'h100, 32'h23, 4'd9, 3);
      fork
         send(4'hE, OP_MOV, 1'b0, 32'd0, 32'h55, 4'd2, 0);
         begin
            repeat (5) begin
               @(negedge clk);
               check("stall_in_ready", 64'(in_ready), 64'(0));
               check("stall_no_issue", 64'(alu_enable), 64'(0));
            end
            ready_mode = 1;
         end
      join

      send(4'hE, OP_ADD, 1'b1, 32'h8000_0000, 32'h8000_0000, 4'd4, 2);
      check("post_rst_skip", 64'(skip_count), 64'(0));

      while (ref_skip != 253) send(4'hF, OP_ADD, 1'b1, 32'd1, 32'd1, 4'd1, 0);
      repeat (3) send(4'hF, $urandom_range(0, 15), 1'b1, $urandom, $urandom, 4'd1, 0);
      check("skip_wrapped", 64'(skip_count), 64'(0));
      check("nv_issue_count", 64'(issues_seen), 64'(exp_issues));

      ready_mode = 2;
      for (int i = 0; i < 300; i++)
         send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
              pick(), pick(), 4'($urandom_range(0, 15)), 0);
      ready_mode = 1;
      repeat (5) @(negedge clk);

      check("wb_queue_drained", 64'(wb_q.size()), 64'(0));
      check("issue_queue_drained", 64'(iss_q.size()), 64'(0));
      check("total_issues", 64'(issues_seen), 64'(exp_issues));
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
